parity_frame_checker: RTL and testbench

PARITY_FRAME_CHECKER -- requirements
Module: parity_frame_checker

---
 rtl/parity_frame_checker.sv | 156 +++++++++++++++
 tb/tb_parity_frame_checker.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/parity_frame_checker.sv
`default_nettype none
// ============================================================================
// Module      : parity_frame_checker
// Description : Streams framed words, checks per-word parity and reports one
//               registered summary (length, errors, column parity) per frame.
// Revision    : 1.0 - initial release
// ============================================================================
module parity_frame_checker #(
   parameter int DATA_W  = 8,
   parameter int MAX_LEN = 16,
   parameter int CNT_W   = 8,
   parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mode_odd,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_par,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_frame_ok,
   output logic [LEN_W-1:0]  out_len,
   output logic [LEN_W-1:0]  out_word_errs,
   output logic [DATA_W-1:0] out_col_par,
   output logic              out_overflow,
   output logic [CNT_W-1:0]  err_count,
   input  logic              clr_count
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCUM  = 2'd1;
   localparam logic [1:0] S_REPORT = 2'd2;

   localparam logic [LEN_W-1:0] c_max_len = LEN_W'(MAX_LEN);
   localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;
   logic              r_mode;
   logic [LEN_W-1:0]  r_len;
   logic [LEN_W-1:0]  r_errs;
   logic [DATA_W-1:0] r_col;
   logic              r_ovf;

   logic              w_accept;
   logic              w_report_hs;
   logic              w_first;
   logic              w_mode;
   logic              w_beat_err;
   logic [LEN_W-1:0]  w_base_len;
   logic [LEN_W-1:0]  w_base_errs;
   logic [DATA_W-1:0] w_base_col;
   logic              w_base_ovf;
   logic [LEN_W-1:0]  w_len_nxt;
   logic [LEN_W-1:0]  w_errs_nxt;
   logic [DATA_W-1:0] w_col_nxt;
   logic              w_ovf_nxt;

   assign w_accept    = in_valid && in_ready;
   assign w_report_hs = out_valid && out_ready;

   // A first beat starts from empty accumulators and uses the live mode input
   assign w_first     = (r_state == S_IDLE);
   assign w_mode      = w_first ? mode_odd : r_mode;
   assign w_base_len  = w_first ? '0 : r_len;
   assign w_base_errs = w_first ? '0 : r_errs;
   assign w_base_col  = w_first ? '0 : r_col;
   assign w_base_ovf  = w_first ? 1'b0 : r_ovf;

   assign w_beat_err  = ((^in_data) ^ in_par) != w_mode;
   assign w_col_nxt   = w_base_col ^ in_data;
   assign w_ovf_nxt   = w_base_ovf || (w_base_len == c_max_len);
   assign w_len_nxt   = (w_base_len == c_max_len) ? c_max_len
                                                  : w_base_len + LEN_W'(1);
   assign w_errs_nxt  = (w_beat_err && (w_base_errs != c_max_len))
                        ? w_base_errs + LEN_W'(1) : w_base_errs;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nxt = in_last ? S_REPORT : S_ACCUM;
            end
         end
         S_ACCUM: begin
            if (w_accept && in_last) begin
               w_state_nxt = S_REPORT;
            end
         end
         S_REPORT: begin
            if (w_report_hs) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (r_state != S_REPORT);
      out_valid = (r_state == S_REPORT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mode        <= 1'b0;
         r_len         <= '0;
         r_errs        <= '0;
         r_col         <= '0;
         r_ovf         <= 1'b0;
         out_frame_ok  <= 1'b0;
         out_len       <= '0;
         out_word_errs <= '0;
         out_col_par   <= '0;
         out_overflow  <= 1'b0;
      end else if (w_accept) begin
         r_mode <= w_mode;
         r_len  <= w_len_nxt;
         r_errs <= w_errs_nxt;
         r_col  <= w_col_nxt;
         r_ovf  <= w_ovf_nxt;
         if (in_last) begin
            out_frame_ok  <= (w_errs_nxt == '0) && !w_ovf_nxt;
            out_len       <= w_len_nxt;
            out_word_errs <= w_errs_nxt;
            out_col_par   <= w_col_nxt;
            out_overflow  <= w_ovf_nxt;
         end
      end
   end

   // Clear wins over a coincident failing-report increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count <= '0;
      end else if (clr_count) begin
         err_count <= '0;
      end else if (w_report_hs && !out_frame_ok && (err_count != c_cnt_max)) begin
         err_count <= err_count + CNT_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_parity_frame_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_parity_frame_checker
// Description : Directed self-checking bench for parity_frame_checker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parity_frame_checker;

   localparam int DATA_W  = 8;
   localparam int MAX_LEN = 4;
   localparam int CNT_W   = 2;
   localparam int LEN_W   = $clog2(MAX_LEN + 1);

   logic              clk = 1'b0;
   logic              rst_n;
   logic              mode_odd;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_par;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic              out_frame_ok;
   logic [LEN_W-1:0]  out_len;
   logic [LEN_W-1:0]  out_word_errs;
   logic [DATA_W-1:0] out_col_par;
   logic              out_overflow;
   logic [CNT_W-1:0]  err_count;
   logic              clr_count;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   parity_frame_checker #(
      .DATA_W (DATA_W),
      .MAX_LEN(MAX_LEN),
      .CNT_W  (CNT_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .mode_odd     (mode_odd),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_par       (in_par),
      .in_last      (in_last),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_frame_ok (out_frame_ok),
      .out_len      (out_len),
      .out_word_errs(out_word_errs),
      .out_col_par  (out_col_par),
      .out_overflow (out_overflow),
      .err_count    (err_count),
      .clr_count    (clr_count)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [7:0] d, input logic p, input logic l);
      in_valid = 1'b1;
      in_data  = d;
      in_par   = p;
      in_last  = l;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic handshake(input logic clr);
      out_ready = 1'b1;
      clr_count = clr;
      tick();
      out_ready = 1'b0;
      clr_count = 1'b0;
   endtask

   task automatic report(input string tag, input logic ok, input logic [LEN_W-1:0] len,
                         input logic [LEN_W-1:0] errs, input logic [7:0] col, input logic ovf);
      chk({tag, ".valid"}, out_valid, 1'b1);
      chk({tag, ".ready"}, in_ready, 1'b0);
      chk({tag, ".ok"}, out_frame_ok, ok);
      chk({tag, ".len"}, out_len, len);
      chk({tag, ".errs"}, out_word_errs, errs);
      chk({tag, ".col"}, out_col_par, col);
      chk({tag, ".ovf"}, out_overflow, ovf);
   endtask

   initial begin
      rst_n = 1'b0; mode_odd = 1'b0; in_valid = 1'b0; in_data = '0;
      in_par = 1'b0; in_last = 1'b0; out_ready = 1'b0; clr_count = 1'b0;
      repeat (3) tick();
      chk("rst.ready", in_ready, 1'b1);
      chk("rst.valid", out_valid, 1'b0);
      chk("rst.err", err_count, 0);
      chk("rst.len", out_len, 0);
      chk("rst.errs", out_word_errs, 0);
      chk("rst.col", out_col_par, 0);
      chk("rst.ovf", out_overflow, 0);
      chk("rst.ok", out_frame_ok, 0);
      rst_n = 1'b1;

      // Odd frame with an idle gap carrying garbage between beats
      mode_odd = 1'b1;
      beat(8'h01, 1'b0, 1'b0);
      in_data = 8'hFF; in_par = 1'b0; in_last = 1'b1;
      tick();
      in_last = 1'b0;
      beat(8'h03, 1'b1, 1'b0);
      chk("a.notyet", out_valid, 1'b0);
      beat(8'h00, 1'b1, 1'b1);
      report("a", 1'b1, 3'd3, 3'd0, 8'h02, 1'b0);
      handshake(1'b0);
      chk("a.idle_valid", out_valid, 1'b0);
      chk("a.idle_ready", in_ready, 1'b1);
      chk("a.err", err_count, 0);

      // Even single-beat with bad parity
      mode_odd = 1'b0;
      beat(8'hFF, 1'b1, 1'b1);
      report("b", 1'b0, 3'd1, 3'd1, 8'hFF, 1'b0);
      handshake(1'b0);
      chk("b.err", err_count, 1);

      // Back-pressure: report must hold while in_valid stays high
      beat(8'h05, 1'b0, 1'b1);
      in_valid = 1'b1; in_data = 8'hAA; in_par = 1'b1; in_last = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         report("c.hold", 1'b1, 3'd1, 3'd0, 8'h05, 1'b0);
      end
      in_valid = 1'b0; in_last = 1'b0;
      handshake(1'b0);
      chk("c.idle_valid", out_valid, 1'b0);
      chk("c.idle_ready", in_ready, 1'b1);
      chk("c.err", err_count, 1);
      tick();
      chk("c.noaccept", out_valid, 1'b0);

      // Overflow with good odd beats; mode flips mid-frame and must be ignored
      mode_odd = 1'b1;
      beat(8'h01, 1'b0, 1'b0);
      mode_odd = 1'b0;
      beat(8'h02, 1'b0, 1'b0);
      beat(8'h04, 1'b0, 1'b0);
      beat(8'h08, 1'b0, 1'b0);
      beat(8'h10, 1'b0, 1'b0);
      chk("d.notyet", out_valid, 1'b0);
      beat(8'h20, 1'b0, 1'b1);
      report("d", 1'b0, 3'd4, 3'd0, 8'h3F, 1'b1);
      handshake(1'b0);
      chk("d.err", err_count, 2);

      // Word-error saturation: five failing even beats
      mode_odd = 1'b0;
      for (int i = 0; i < 4; i++) beat(8'h01, 1'b0, 1'b0);
      beat(8'h01, 1'b0, 1'b1);
      report("e", 1'b0, 3'd4, 3'd4, 8'h01, 1'b1);
      handshake(1'b0);
      chk("e.err", err_count, 3);
      beat(8'hFF, 1'b1, 1'b1);
      handshake(1'b0);
      chk("e.err_sat", err_count, 3);

      // Asynchronous reset mid-frame discards the frame
      beat(8'h00, 1'b0, 1'b0);
      beat(8'h00, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("f.async_err", err_count, 0);
      chk("f.async_ready", in_ready, 1'b1);
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      chk("f.noreport", out_valid, 1'b0);
      mode_odd = 1'b1;
      beat(8'h80, 1'b0, 1'b0);
      beat(8'h07, 1'b0, 1'b1);
      report("f", 1'b1, 3'd2, 3'd0, 8'h87, 1'b0);
      handshake(1'b0);
      chk("f.err", err_count, 0);

      // Clear coincident with a failing report handshake
      mode_odd = 1'b0;
      beat(8'h01, 1'b0, 1'b1);
      report("g", 1'b0, 3'd1, 3'd1, 8'h01, 1'b0);
      handshake(1'b1);
      chk("g.clr_priority", err_count, 0);
      chk("g.idle_ready", in_ready, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
